// File: rtl/led_reg_unit.sv
// Memory-mapped LED register block: static pattern, per-LED blink mask and blink half-period.
// Optional PWM dimming (register PWM_DUTY at address 3) is compiled in with `define LED_PWM_EN.
module led_reg_unit #(
  parameter int LED_W    = 10,
  parameter int PERIOD_W = 24,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        bus_addr,
  input  logic              bus_we,
  input  logic              bus_re,
  input  logic [DATA_W-1:0] bus_wdata,
  output logic [DATA_W-1:0] bus_rdata,
  output logic              bus_rvalid,
  output logic [LED_W-1:0]  led_reg
);

  localparam logic [1:0] ADDR_VALUE  = 2'd0;
  localparam logic [1:0] ADDR_MASK   = 2'd1;
  localparam logic [1:0] ADDR_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_DUTY   = 2'd3;

  logic [LED_W-1:0]    value_r;
  logic [LED_W-1:0]    mask_r;
  logic [PERIOD_W-1:0] period_r;
  logic [PERIOD_W-1:0] cnt;
  logic                phase;
  logic                pwm_gate;
  logic [DATA_W-1:0]   rd_mux;
  logic                wr_period;
  logic                unused_wdata;

  // Only the low bits of each write are stored; the rest is deliberately dropped.
  assign unused_wdata = ^bus_wdata;
  assign wr_period    = bus_we && (bus_addr == ADDR_PERIOD);

  always_ff @(posedge clk) begin
    if (rst) begin
      value_r  <= '0;
      mask_r   <= '0;
      period_r <= '0;
    end else if (bus_we) begin
      case (bus_addr)
        ADDR_VALUE:  value_r  <= bus_wdata[LED_W-1:0];
        ADDR_MASK:   mask_r   <= bus_wdata[LED_W-1:0];
        ADDR_PERIOD: period_r <= bus_wdata[PERIOD_W-1:0];
        default:     ;
      endcase
    end
  end

  // A PERIOD write restarts the blink so a shrinking period never leaves cnt past the wrap point.
  always_ff @(posedge clk) begin
    if (rst || wr_period || (period_r == '0)) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == period_r - PERIOD_W'(1)) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + PERIOD_W'(1);
    end
  end

`ifdef LED_PWM_EN
  logic [7:0] pwm_cnt;
  logic [7:0] duty_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
      duty_r  <= 8'hFF;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      if (bus_we && (bus_addr == ADDR_DUTY))
        duty_r <= bus_wdata[7:0];
    end
  end

  assign pwm_gate = (pwm_cnt < duty_r) || (duty_r == 8'hFF);
`else
  assign pwm_gate = 1'b1;
`endif

  always_comb begin
    rd_mux = '0;
    case (bus_addr)
      ADDR_VALUE:  rd_mux = DATA_W'(value_r);
      ADDR_MASK:   rd_mux = DATA_W'(mask_r);
      ADDR_PERIOD: rd_mux = DATA_W'(period_r);
`ifdef LED_PWM_EN
      ADDR_DUTY:   rd_mux = DATA_W'(duty_r);
`endif
      default:     rd_mux = '0;
    endcase
  end

  // Bus protocol: bus_we/bus_re are single-cycle strobes with no backpressure; a read strobe
  // in cycle N returns bus_rvalid=1 with data in cycle N+1, sampled before any same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_rdata  <= '0;
      bus_rvalid <= 1'b0;
    end else begin
      bus_rvalid <= bus_re;
      if (bus_re)
        bus_rdata <= rd_mux;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      led_reg <= '0;
    else
      led_reg <= ((value_r & ~mask_r) | (value_r & mask_r & {LED_W{phase}}))
                 & {LED_W{pwm_gate}};
  end

endmodule

// File: tb/tb_led_reg_unit.sv
// Self-checking bench for led_reg_unit; read data goes through an expected queue,
// LED blink sequences through a second queue of expected led_reg values.
module tb_led_reg_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  bus_addr;
  logic        bus_we;
  logic        bus_re;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;
  logic [9:0]  led_reg;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [9:0]  led_q[$];

  led_reg_unit dut (
    .clk        (clk),
    .rst        (rst),
    .bus_addr   (bus_addr),
    .bus_we     (bus_we),
    .bus_re     (bus_re),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_rvalid (bus_rvalid),
    .led_reg    (led_reg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // read scoreboard
  always @(negedge clk) begin
    if (rst === 1'b0 && bus_rvalid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rdata_unexpected: rvalid with no pending read, rdata=%h", bus_rdata);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (bus_rdata !== e) begin
          errors++;
          $display("FAIL rdata: got %h expected %h", bus_rdata, e);
        end
      end
    end
  end

  // driver tasks
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_addr = a; bus_wdata = d; bus_we = 1'b1;
    @(negedge clk);
    bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] expv);
    @(negedge clk);
    bus_addr = a; bus_re = 1'b1;
    exp_q.push_back(expv);
    @(negedge clk);
    bus_re = 1'b0;
  endtask

  // Call right after a PERIOD write with VALUE=0x3FF, MASK=0x00F.
  task automatic check_blink(input int period, input int ncyc);
    logic [9:0] e;
    for (int j = 1; j <= ncyc; j++)
      led_q.push_back((((j - 1) / period) % 2) == 1 ? 10'h3FF : 10'h3F0);
    for (int j = 1; j <= ncyc; j++) begin
      @(negedge clk);
      e = led_q.pop_front();
      checks++;
      if (led_reg !== e) begin
        errors++;
        $display("FAIL blink_p%0d_c%0d: led_reg=%h expected %h", period, j, led_reg, e);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; bus_we = 1'b0; bus_re = 1'b0; bus_addr = '0; bus_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      checks++;
      if (led_reg !== 10'h0 || bus_rvalid !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle: led_reg=%h rvalid=%b expected 000/0", led_reg, bus_rvalid);
      end
    end
    checks++;
    if (bus_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h expected 0", bus_rdata);
    end
`ifdef LED_PWM_EN
    bus_read(2'd3, 32'h0000_00FF);
`else
    bus_read(2'd3, 32'h0);
`endif
    bus_read(2'd0, 32'h0);
    bus_read(2'd1, 32'h0);
    bus_read(2'd2, 32'h0);
  endtask

  task automatic test_static;
    bus_write(2'd1, 32'h0);
    bus_write(2'd0, 32'hFFFF_F2A5);
    repeat (10) begin
      @(negedge clk);
      checks++;
      if (led_reg !== 10'h2A5) begin
        errors++;
        $display("FAIL static_value: led_reg=%h expected 2a5", led_reg);
      end
    end
    bus_read(2'd0, 32'h0000_02A5);
    bus_read(2'd1, 32'h0);
  endtask

  task automatic test_blink;
    bus_write(2'd1, 32'h0000_000F);
    bus_write(2'd0, 32'h0000_03FF);
    bus_write(2'd2, 32'hFF00_0004);
    check_blink(4, 21);
    // rewrite lands mid-way through a lit phase
    bus_write(2'd2, 32'h0000_0002);
    check_blink(2, 8);
    bus_read(2'd2, 32'h0000_0002);
  endtask

  task automatic test_period_zero;
    int lit;
    bus_write(2'd2, 32'h0);
    bus_write(2'd1, 32'h0000_03FF);
    bus_write(2'd0, 32'h0000_0155);
    @(negedge clk);
    repeat (20) begin
      @(negedge clk);
      checks++;
      if (led_reg !== 10'h0) begin
        errors++;
        $display("FAIL period_zero: led_reg=%h expected 000", led_reg);
      end
    end
    bus_write(2'd0, 32'h0000_03FF);
    bus_write(2'd2, 32'h00FF_FFFF);
    lit = 0;
    repeat (1000) begin
      @(negedge clk);
      if (led_reg !== 10'h0) lit++;
    end
    checks++;
    if (lit !== 0) begin
      errors++;
      $display("FAIL period_max_toggle: lit cycles=%0d expected 0", lit);
    end
    bus_read(2'd2, 32'h00FF_FFFF);
  endtask

  task automatic test_same_cycle;
    bus_write(2'd2, 32'h0000_0123);
    bus_write(2'd1, 32'h0);
    bus_write(2'd0, 32'h0000_0001);
    @(negedge clk);
    bus_addr = 2'd0; bus_wdata = 32'h0000_0002; bus_we = 1'b1; bus_re = 1'b1;
    exp_q.push_back(32'h0000_0001);
    @(negedge clk);
    bus_we = 1'b0; bus_re = 1'b0;
    bus_read(2'd0, 32'h0000_0002);
    checks++;
    if (led_reg !== 10'h002) begin
      errors++;
      $display("FAIL same_cycle_led: led_reg=%h expected 002", led_reg);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    bus_re = 1'b1; bus_addr = 2'd2; exp_q.push_back(32'h0000_0123);
    @(negedge clk);
    bus_addr = 2'd1; exp_q.push_back(32'h0);
    @(negedge clk);
    bus_addr = 2'd0; exp_q.push_back(32'h0000_0002);
    @(negedge clk);
    bus_re = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus_rvalid !== 1'b0 || bus_rdata !== 32'h0000_0002) begin
        errors++;
        $display("FAIL rdata_hold: rvalid=%b rdata=%h expected 0/00000002", bus_rvalid, bus_rdata);
      end
    end
  endtask

  task automatic test_pwm;
    int on_cnt;
    bus_write(2'd2, 32'h0);
    bus_write(2'd1, 32'h0);
    bus_write(2'd0, 32'h0000_03FF);
    bus_write(2'd3, 32'hFFFF_FF40);
`ifdef LED_PWM_EN
    bus_read(2'd3, 32'h0000_0040);
    @(negedge clk);
    on_cnt = 0;
    repeat (256) begin
      @(negedge clk);
      if (led_reg === 10'h3FF) on_cnt++;
    end
    checks++;
    if (on_cnt !== 64) begin
      errors++;
      $display("FAIL pwm_duty64: on cycles=%0d expected 64", on_cnt);
    end
    bus_write(2'd3, 32'h0);
    @(negedge clk);
    on_cnt = 0;
    repeat (256) begin
      @(negedge clk);
      if (led_reg !== 10'h0) on_cnt++;
    end
    checks++;
    if (on_cnt !== 0) begin
      errors++;
      $display("FAIL pwm_duty0: lit cycles=%0d expected 0", on_cnt);
    end
    bus_write(2'd3, 32'h0000_00FF);
`else
    bus_read(2'd3, 32'h0);
    repeat (10) begin
      @(negedge clk);
      checks++;
      if (led_reg !== 10'h3FF) begin
        errors++;
        $display("FAIL no_pwm_led: led_reg=%h expected 3ff", led_reg);
      end
    end
`endif
  endtask

  task automatic test_reset_mid_blink;
    bus_write(2'd1, 32'h0000_000F);
    bus_write(2'd0, 32'h0000_03FF);
    bus_write(2'd2, 32'h0000_0003);
    bus_read(2'd0, 32'h0000_03FF);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (led_reg !== 10'h0 || bus_rvalid !== 1'b0 || bus_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_blink: led=%h rvalid=%b rdata=%h expected 0/0/0",
               led_reg, bus_rvalid, bus_rdata);
    end
    rst = 1'b0;
    bus_read(2'd0, 32'h0);
    bus_read(2'd1, 32'h0);
    bus_read(2'd2, 32'h0);
`ifdef LED_PWM_EN
    bus_read(2'd3, 32'h0000_00FF);
`else
    bus_read(2'd3, 32'h0);
`endif
    checks++;
    if (led_reg !== 10'h0) begin
      errors++;
      $display("FAIL reset_led_after: led_reg=%h expected 000", led_reg);
    end
  endtask

  initial begin
    test_reset();
    test_static();
    test_blink();
    test_period_zero();
    test_same_cycle();
    test_back_to_back();
    test_pwm();
    test_reset_mid_blink();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL read_drain: %0d reads never returned, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
